// File: rtl/simon_host_if.sv
// Host-side serial loader/unloader for a bit-serial SIMON core: shifts plaintext and an all-zero key in,
// then collects the serial ciphertext (first rdy=11 cycle 2*BLOCK_BITS+1 after start; no backpressure, start ignored while busy).
module simon_host_if #(
  parameter int BLOCK_BITS = 128,
  parameter int TIMEOUT    = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BLOCK_BITS-1:0] pt_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [BLOCK_BITS-1:0] ct_out,
  output logic                  core_data_in,
  output logic [1:0]            core_data_rdy,
  input  logic                  core_cipher_out,
  input  logic                  core_valid
);

  localparam int CW = $clog2(BLOCK_BITS) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_PT  = 3'd1;
  localparam logic [2:0] S_LOAD_KEY = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_CAPTURE  = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         timer;
  logic [BLOCK_BITS-1:0] tx_sr;
  logic [BLOCK_BITS-1:0] rx_sr;
  logic [BLOCK_BITS-1:0] rx_next;

  // New bits enter at the MSB so the first received bit lands in bit 0 after a full block.
  assign rx_next = {core_cipher_out, rx_sr[BLOCK_BITS-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      ct_out <= '0;
      cnt    <= '0;
      timer  <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tx_sr <= pt_in;
            cnt   <= '0;
            timer <= '0;
            busy  <= 1'b1;
            state <= S_LOAD_PT;
          end
        end
        S_LOAD_PT: begin
          tx_sr <= tx_sr >> 1;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_LOAD_KEY;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_LOAD_KEY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          timer <= timer + TMR_ONE;
          // A valid bit on the last allowed cycle still wins over the timeout.
          if (core_valid) begin
            rx_sr <= rx_next;
            cnt   <= CNT_ONE;
            state <= S_CAPTURE;
          end else if (timer == TMR_LAST) begin
            done  <= 1'b1;
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (core_valid) begin
            rx_sr <= rx_next;
            if (cnt == CNT_LAST) begin
              ct_out <= rx_next;
              cnt    <= '0;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    core_data_rdy = 2'b00;
    case (state)
      S_LOAD_PT:           core_data_rdy = 2'b01;
      S_LOAD_KEY:          core_data_rdy = 2'b10;
      S_RUN, S_CAPTURE:    core_data_rdy = 2'b11;
      default:             core_data_rdy = 2'b00;
    endcase
  end

  assign core_data_in = (state == S_LOAD_PT) & tx_sr[0];

endmodule

// File: tb/tb_simon_host_if.sv
// Bench for simon_host_if: per-cycle expectations derived from cycle index since start and a scripted core model.
module tb_simon_host_if;

  localparam int B  = 128;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [B-1:0] pt_in;
  logic         busy;
  logic         done;
  logic         error;
  logic [B-1:0] ct_out;
  logic         core_data_in;
  logic [1:0]   core_data_rdy;
  logic         core_cipher_out;
  logic         core_valid;

  int           checks   = 0;
  int           failures = 0;
  logic [B-1:0] prev_ct;

  simon_host_if #(.BLOCK_BITS(B), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .pt_in           (pt_in),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .ct_out          (ct_out),
    .core_data_in    (core_data_in),
    .core_data_rdy   (core_data_rdy),
    .core_cipher_out (core_cipher_out),
    .core_valid      (core_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [B-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transfer. Cycle k=1 is the first cycle after the start-accepting edge.
  // mode: 0 continuous valid, 1 alternating valid, 2 random valid; delay = idle RUN cycles before first valid.
  task automatic run_txn(input logic [B-1:0] pt, input logic [B-1:0] ct,
                         input int delay, input int mode, input bit noisy);
    int  k, sent, run_cyc;
    bit  fin, v;
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    start = 1'b1;
    pt_in = pt;
    @(negedge clk);
    start = 1'b0;
    pt_in = ~pt;
    k = 1; sent = 0; run_cyc = 0; fin = 0;
    while (!fin) begin
      if (k > 2*B + TO + 6*B) begin
        check_eq("txn_bound", 1'b1, 1'b0);
        fin = 1;
      end else if (k <= B) begin
        check_eq("pt_rdy", core_data_rdy, 2'b01);
        check_eq("pt_din", core_data_in, pt[k-1]);
      end else if (k <= 2*B) begin
        check_eq("key_rdy", core_data_rdy, 2'b10);
        check_eq("key_din", core_data_in, 1'b0);
      end else if (sent == B) begin
        check_eq("ok_done", done, 1'b1);
        check_eq("ok_err", error, 1'b0);
        check_eq("ok_busy", busy, 1'b0);
        check_eq("ok_rdy", core_data_rdy, 2'b00);
        check_eq("ok_ct", ct_out, ct);
        prev_ct = ct;
        fin = 1;
      end else if (sent == 0 && run_cyc == TO) begin
        check_eq("to_done", done, 1'b1);
        check_eq("to_err", error, 1'b1);
        check_eq("to_busy", busy, 1'b0);
        check_eq("to_rdy", core_data_rdy, 2'b00);
        check_eq("to_ct", ct_out, prev_ct);
        fin = 1;
      end else begin
        check_eq("run_rdy", core_data_rdy, 2'b11);
        check_eq("run_din", core_data_in, 1'b0);
      end
      if (!fin) begin
        check_eq("act_busy", busy, 1'b1);
        check_eq("act_done", done, 1'b0);
      end
      start           = 1'b0;
      core_valid      = 1'b0;
      core_cipher_out = 1'($urandom);
      if (!fin) begin
        if (noisy && $urandom_range(0, 7) == 0) begin
          start = 1'b1;
          pt_in = rand_blk();
        end
        if (k > 2*B) begin
          v = 0;
          if (run_cyc >= delay) begin
            case (mode)
              0:       v = 1;
              1:       v = ((run_cyc - delay) % 2) == 0;
              default: v = 1'($urandom_range(0, 1));
            endcase
          end
          if (v && sent < B) begin
            core_valid      = 1'b1;
            core_cipher_out = ct[sent];
            sent++;
          end
          run_cyc++;
        end
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    check_eq("pulse_done", done, 1'b0);
    check_eq("pulse_busy", busy, 1'b0);
  endtask

  task automatic reset_mid_key();
    @(negedge clk);
    start = 1'b1;
    pt_in = rand_blk();
    @(negedge clk);
    start = 1'b0;
    repeat (B + 20) @(negedge clk);
    check_eq("pre_rst_rdy", core_data_rdy, 2'b10);
    #2 reset = 1'b1;
    #1;
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_done", done, 1'b0);
    check_eq("mrst_err", error, 1'b0);
    check_eq("mrst_ct", ct_out, '0);
    check_eq("mrst_din", core_data_in, 1'b0);
    check_eq("mrst_rdy", core_data_rdy, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    prev_ct = '0;
    repeat (5) begin
      @(negedge clk);
      check_eq("post_rst_busy", busy, 1'b0);
      check_eq("post_rst_rdy", core_data_rdy, 2'b00);
    end
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    pt_in           = '0;
    core_valid      = 1'b0;
    core_cipher_out = 1'b0;
    prev_ct         = '0;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", error, 1'b0);
    check_eq("rst_ct", ct_out, '0);
    check_eq("rst_din", core_data_in, 1'b0);
    check_eq("rst_rdy", core_data_rdy, 2'b00);
    #20;
    @(negedge clk);
    reset = 1'b0;

    run_txn(128'h1, {16{8'hA5}}, 0, 0, 1'b0);
    run_txn(rand_blk(), rand_blk(), 3, 1, 1'b1);
    run_txn(rand_blk(), rand_blk(), TO, 0, 1'b0);
    run_txn(rand_blk(), rand_blk(), TO - 1, 0, 1'b0);
    reset_mid_key();
    for (int i = 0; i < 6; i++)
      run_txn(rand_blk(), rand_blk(), $urandom_range(0, TO + 2), $urandom_range(0, 2), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
